// File: rtl/stop_watch_ctrl.sv
// Stop-watch control sequencer: conditions the start/stop and lap/clear buttons,
// runs the IDLE/RUN/LAP/STOP machine, latches lap times and selects the display source.
module stop_watch_ctrl #(
    parameter int unsigned DEB_CYCLES = 160,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       I_CLK,
    input  logic       I_RESN,
    input  logic       I_BTN_SS,
    input  logic       I_BTN_LC,
    input  logic [9:0] I_TIMER_MS,
    input  logic [5:0] I_TIMER_SEC,
    output logic       O_EN,
    output logic       O_CLR,
    output logic [9:0] O_DISP_MS,
    output logic [5:0] O_DISP_SEC,
    output logic       O_LAP_VALID,
    output logic [3:0] O_LAP_CNT,
    output logic [1:0] O_STATE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAP  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Bit 0 carries the start/stop button, bit 1 the lap/clear button.
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            deb_q, deb_d, deb_prev_q;
    logic [1:0]            press_s;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                  ss_s, lc_s;

    state_t     state_q, state_d;
    logic       en_q, en_d;
    logic       clr_q, clr_d;
    logic       lap_valid_q, lap_valid_d;
    logic [3:0] lap_cnt_q, lap_cnt_d;
    logic [9:0] lap_ms_q, lap_ms_d;
    logic [5:0] lap_sec_q, lap_sec_d;

    // Debounce: accept a new level only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] == deb_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == DEB_MAX) begin
                deb_d[b] = sync2_q[b];
                cnt_d[b] = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + CNT_ONE;
            end
        end
    end

    assign press_s = deb_q & ~deb_prev_q;
    assign ss_s    = press_s[0];
    assign lc_s    = press_s[1];

    // Next-state and registered-output logic; start/stop wins over a coincident lap/clear.
    always_comb begin
        state_d   = state_q;
        clr_d     = 1'b0;
        lap_cnt_d = lap_cnt_q;
        lap_ms_d  = lap_ms_q;
        lap_sec_d = lap_sec_q;
        case (state_q)
            ST_IDLE: begin
                if (ss_s) begin
                    state_d = ST_RUN;
                end else if (lc_s) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ss_s) begin
                    state_d = ST_STOP;
                end else if (lc_s) begin
                    state_d   = ST_LAP;
                    lap_ms_d  = I_TIMER_MS;
                    lap_sec_d = I_TIMER_SEC;
                    lap_cnt_d = (lap_cnt_q == 4'd15) ? 4'd15 : lap_cnt_q + 4'd1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LAP: begin
                if (ss_s) begin
                    state_d = ST_STOP;
                end else if (lc_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_LAP;
                end
            end
            ST_STOP: begin
                if (ss_s) begin
                    state_d = ST_RUN;
                end else if (lc_s) begin
                    state_d   = ST_IDLE;
                    clr_d     = 1'b1;
                    lap_cnt_d = 4'd0;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        en_d        = (state_d == ST_RUN) || (state_d == ST_LAP);
        lap_valid_d = (state_d == ST_LAP);
    end

    // All state, including the button conditioners, with synchronous active-low reset.
    always_ff @(posedge I_CLK) begin
        if (!I_RESN) begin
            sync1_q     <= 2'b00;
            sync2_q     <= 2'b00;
            deb_q       <= 2'b00;
            deb_prev_q  <= 2'b00;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            en_q        <= 1'b0;
            clr_q       <= 1'b0;
            lap_valid_q <= 1'b0;
            lap_cnt_q   <= 4'd0;
            lap_ms_q    <= 10'd0;
            lap_sec_q   <= 6'd0;
        end else begin
            sync1_q     <= {I_BTN_LC, I_BTN_SS};
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_q;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            en_q        <= en_d;
            clr_q       <= clr_d;
            lap_valid_q <= lap_valid_d;
            lap_cnt_q   <= lap_cnt_d;
            lap_ms_q    <= lap_ms_d;
            lap_sec_q   <= lap_sec_d;
        end
    end

    assign O_EN        = en_q;
    assign O_CLR       = clr_q;
    assign O_LAP_VALID = lap_valid_q;
    assign O_LAP_CNT   = lap_cnt_q;
    assign O_STATE     = state_q;
    assign O_DISP_MS   = (state_q == ST_LAP) ? lap_ms_q  : I_TIMER_MS;
    assign O_DISP_SEC  = (state_q == ST_LAP) ? lap_sec_q : I_TIMER_SEC;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Self-checking bench for stop_watch_ctrl: a cycle model built from the button
// and state-machine rules is compared every cycle, plus directed literal checks.
module tb_stop_watch_ctrl;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       resn;
    logic       btn_ss, btn_lc;
    logic [9:0] timer_ms;
    logic [5:0] timer_sec;
    logic       O_EN, O_CLR, O_LAP_VALID;
    logic [9:0] O_DISP_MS;
    logic [5:0] O_DISP_SEC;
    logic [3:0] O_LAP_CNT;
    logic [1:0] O_STATE;

    int n_checks = 0;
    int n_fail   = 0;

    stop_watch_ctrl #(.DEB_CYCLES(DEB), .CNT_W(16)) dut (
        .I_CLK       (clk),
        .I_RESN      (resn),
        .I_BTN_SS    (btn_ss),
        .I_BTN_LC    (btn_lc),
        .I_TIMER_MS  (timer_ms),
        .I_TIMER_SEC (timer_sec),
        .O_EN        (O_EN),
        .O_CLR       (O_CLR),
        .O_DISP_MS   (O_DISP_MS),
        .O_DISP_SEC  (O_DISP_SEC),
        .O_LAP_VALID (O_LAP_VALID),
        .O_LAP_CNT   (O_LAP_CNT),
        .O_STATE     (O_STATE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw samples history, accepted levels, pending presses, machine state.
    int m_state, m_lapcnt, m_lap_ms, m_lap_sec;
    bit m_clr, m_valid = 1'b0;
    bit m_hist [2][DEB+2];
    bit m_deb [2];
    bit m_pend [2];
    bit m_ss, m_lc, m_all_diff;

    always @(posedge clk) begin
        if (!resn) begin
            m_state = 0; m_clr = 0; m_lapcnt = 0; m_lap_ms = 0; m_lap_sec = 0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEB + 2; i++) m_hist[b][i] = 1'b0;
                m_deb[b] = 1'b0;
                m_pend[b] = 1'b0;
            end
            m_valid = 1'b1;
        end else begin
            m_ss = m_pend[0];
            m_lc = m_pend[1];
            m_clr = 1'b0;
            if (m_ss) begin
                m_state = (m_state == 1 || m_state == 2) ? 3 : 1;
            end else if (m_lc) begin
                if (m_state == 0) begin
                    m_clr = 1'b1;
                end else if (m_state == 1) begin
                    m_state = 2;
                    m_lap_ms = timer_ms;
                    m_lap_sec = timer_sec;
                    m_lapcnt = (m_lapcnt >= 15) ? 15 : m_lapcnt + 1;
                end else if (m_state == 2) begin
                    m_state = 1;
                end else begin
                    m_state = 0;
                    m_clr = 1'b1;
                    m_lapcnt = 0;
                end
            end
            // A level is accepted once DEB consecutive two-clock-delayed samples disagree with it.
            for (int b = 0; b < 2; b++) begin
                for (int i = DEB + 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
                m_hist[b][0] = (b == 0) ? btn_ss : btn_lc;
                m_all_diff = 1'b1;
                for (int i = 2; i < DEB + 2; i++)
                    if (m_hist[b][i] == m_deb[b]) m_all_diff = 1'b0;
                m_pend[b] = m_all_diff && !m_deb[b];
                if (m_all_diff) m_deb[b] = !m_deb[b];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            chk("state", O_STATE, m_state);
            chk("en", O_EN, (m_state == 1 || m_state == 2) ? 1 : 0);
            chk("clr", O_CLR, m_clr);
            chk("lap_valid", O_LAP_VALID, (m_state == 2) ? 1 : 0);
            chk("lap_cnt", O_LAP_CNT, m_lapcnt);
            chk("disp_ms", O_DISP_MS, (m_state == 2) ? m_lap_ms : int'(timer_ms));
            chk("disp_sec", O_DISP_SEC, (m_state == 2) ? m_lap_sec : int'(timer_sec));
        end
    end

    int clr_seen = 0;
    int trans_cnt = 0;
    logic [1:0] prev_st = 2'bxx;
    always @(negedge clk) begin
        if (O_CLR === 1'b1) clr_seen++;
        if (O_STATE !== prev_st) trans_cnt++;
        prev_st = O_STATE;
    end

    task automatic press(input bit ss, input bit lc);
        btn_ss = ss;
        btn_lc = lc;
        repeat (6) @(negedge clk);
        btn_ss = 1'b0;
        btn_lc = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    int c0, t0;

    initial begin
        resn = 1'b0; btn_ss = 1'b0; btn_lc = 1'b0; timer_ms = 10'd0; timer_sec = 6'd0;
        repeat (10) @(negedge clk);
        chk("rst_state", O_STATE, 0);
        chk("rst_en", O_EN, 0);
        chk("rst_clr", O_CLR, 0);
        chk("rst_lap_valid", O_LAP_VALID, 0);
        chk("rst_lap_cnt", O_LAP_CNT, 0);
        chk("rst_disp_ms", O_DISP_MS, 0);
        chk("rst_disp_sec", O_DISP_SEC, 0);
        resn = 1'b1;
        repeat (3) @(negedge clk);

        // Latency from raw rise to state change.
        btn_ss = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 6) begin
                btn_ss = 1'b0;
                chk("lat_early", O_STATE, 0);
            end
        end
        chk("lat_state", O_STATE, 1);
        chk("lat_en", O_EN, 1);
        repeat (10) @(negedge clk);

        // Bounce alone, then bounce followed by a clean hold.
        t0 = trans_cnt;
        for (int i = 0; i < 4; i++) begin
            btn_ss = (i % 2 == 0);
            @(negedge clk);
        end
        btn_ss = 1'b0;
        repeat (8) @(negedge clk);
        chk("bounce_none", trans_cnt - t0, 0);
        chk("bounce_state", O_STATE, 1);
        t0 = trans_cnt;
        for (int i = 0; i < 4; i++) begin
            btn_ss = (i % 2 == 0);
            @(negedge clk);
        end
        press(1'b1, 1'b0);
        chk("bounce_one", trans_cnt - t0, 1);
        chk("stop_state", O_STATE, 3);
        chk("stop_en", O_EN, 0);

        // Lap freeze and release.
        press(1'b1, 1'b0);
        chk("run_again", O_STATE, 1);
        timer_ms = 10'd345; timer_sec = 6'd12;
        press(1'b0, 1'b1);
        chk("lap_state", O_STATE, 2);
        chk("lap_ms", O_DISP_MS, 345);
        chk("lap_sec", O_DISP_SEC, 12);
        chk("lap_cnt1", O_LAP_CNT, 1);
        chk("lap_valid", O_LAP_VALID, 1);
        timer_ms = 10'd500; timer_sec = 6'd13;
        @(negedge clk);
        chk("frozen_ms", O_DISP_MS, 345);
        chk("frozen_sec", O_DISP_SEC, 12);
        chk("lap_en", O_EN, 1);
        press(1'b0, 1'b1);
        chk("unlap_state", O_STATE, 1);
        chk("live_ms", O_DISP_MS, 500);
        chk("live_sec", O_DISP_SEC, 13);
        chk("unlap_valid", O_LAP_VALID, 0);

        // Lap captured at 59.999 survives the live wrap.
        timer_ms = 10'd999; timer_sec = 6'd59;
        press(1'b0, 1'b1);
        timer_ms = 10'd0; timer_sec = 6'd0;
        @(negedge clk);
        chk("wrap_ms", O_DISP_MS, 999);
        chk("wrap_sec", O_DISP_SEC, 59);
        chk("lap_cnt2", O_LAP_CNT, 2);
        press(1'b0, 1'b1);

        // Stop, clear, clear again in IDLE.
        press(1'b1, 1'b0);
        chk("stop2_state", O_STATE, 3);
        chk("stop2_en", O_EN, 0);
        c0 = clr_seen;
        press(1'b0, 1'b1);
        chk("clr_once", clr_seen - c0, 1);
        chk("clr_state", O_STATE, 0);
        chk("clr_lap_cnt", O_LAP_CNT, 0);
        c0 = clr_seen;
        press(1'b0, 1'b1);
        chk("idle_clr_once", clr_seen - c0, 1);
        chk("idle_state", O_STATE, 0);

        // Coincident presses: start/stop wins.
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        chk("pre_sim_cnt", O_LAP_CNT, 1);
        press(1'b1, 1'b1);
        chk("sim_state", O_STATE, 3);
        chk("sim_lap_cnt", O_LAP_CNT, 1);

        // Lap counter saturation.
        press(1'b1, 1'b0);
        for (int i = 0; i < 17; i++) begin
            press(1'b0, 1'b1);
            press(1'b0, 1'b1);
        end
        chk("sat_cnt", O_LAP_CNT, 15);
        chk("sat_state", O_STATE, 1);
        press(1'b0, 1'b1);
        chk("sat_lap_state", O_STATE, 2);
        chk("sat_cnt2", O_LAP_CNT, 15);

        // Reset in LAP with a lap/clear debounce in progress.
        c0 = clr_seen;
        btn_lc = 1'b1;
        repeat (3) @(negedge clk);
        resn = 1'b0;
        btn_lc = 1'b0;
        @(negedge clk);
        chk("mid_rst_state", O_STATE, 0);
        chk("mid_rst_en", O_EN, 0);
        chk("mid_rst_clr", O_CLR, 0);
        chk("mid_rst_valid", O_LAP_VALID, 0);
        chk("mid_rst_cnt", O_LAP_CNT, 0);
        chk("mid_rst_ms", O_DISP_MS, 0);
        chk("mid_rst_sec", O_DISP_SEC, 0);
        resn = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_rst_state", O_STATE, 0);
        chk("post_rst_no_clr", clr_seen - c0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
